// File: rtl/tinyalu_cmd_sequencer.sv
// tinyalu_cmd_sequencer
//
// Upstream driver for the TinyALU. Tagged commands come in on a valid/ready
// port and are buffered in a small FIFO. They are issued one at a time on the
// ALU's level-start / done-pulse interface. Each result is returned with its
// tag on a single-slot valid/ready response port.
//
// NOP commands are answered locally without touching the ALU. An operation
// that never sees alu_done is aborted after TIMEOUT cycles and answered with
// rsp_err=1. After every issued operation alu_start is held low for GAP cycles
// so the ALU's pipelined done logic can flush.
//
// Handshake rule for both cmd_* and rsp_*: a transfer happens at a rising clk
// edge where valid and ready are both 1. A producer holding valid keeps its
// payload stable until that edge. cmd_ready depends only on FIFO fullness.
// rsp_* stays frozen while rsp_valid=1 and rsp_ready=0.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   cmd_valid/ready     command handshake (ready = FIFO not full)
//   cmd_a, cmd_b        8-bit operands
//   cmd_op              000 nop, 001 add, 010 and, 011 xor, 1xx mul
//   cmd_tag             echoed back on rsp_tag
//   alu_A/B/op          registered operands/op to the ALU
//   alu_start           high from issue until alu_done is sampled (or abort)
//   alu_done            ALU completion pulse; alu_result valid with it
//   alu_result          16-bit ALU result
//   rsp_valid/ready     response handshake
//   rsp_result/tag/err  response payload; err=1 marks a timeout abort
//   busy                FSM not idle, FIFO non-empty, or response pending
module tinyalu_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 16,
  parameter int GAP     = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic [2:0]       cmd_op,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [7:0]       alu_A,
  output logic [7:0]       alu_B,
  output logic [2:0]       alu_op,
  output logic             alu_start,
  input  logic             alu_done,
  input  logic [15:0]      alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT);
  localparam int GW = $clog2(GAP);
  localparam logic [AW:0]   FULL_CNT   = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] TIMER_LAST = CW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t state;

  // ---------------- command FIFO ----------------
  logic [7:0]       fifo_a   [DEPTH];
  logic [7:0]       fifo_b   [DEPTH];
  logic [2:0]       fifo_op  [DEPTH];
  logic [TAG_W-1:0] fifo_tag [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             fifo_empty;
  logic             push, pop;

  assign fifo_empty = (count == '0);
  assign cmd_ready  = (count != FULL_CNT);
  assign push       = cmd_valid && cmd_ready;
  // The FSM pops only from IDLE and only once the response slot is free.
  assign pop        = (state == S_IDLE) && !fifo_empty && !rsp_valid;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a[wr_ptr]   <= cmd_a;
      fifo_b[wr_ptr]   <= cmd_b;
      fifo_op[wr_ptr]  <= cmd_op;
      fifo_tag[wr_ptr] <= cmd_tag;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------- issue FSM ----------------
  logic [CW-1:0]    timer;
  logic [GW-1:0]    gap_cnt;
  logic [TAG_W-1:0] cur_tag;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      alu_A      <= '0;
      alu_B      <= '0;
      alu_op     <= '0;
      alu_start  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_tag    <= '0;
      rsp_err    <= 1'b0;
      timer      <= '0;
      gap_cnt    <= '0;
      cur_tag    <= '0;
    end else begin
      if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (pop) begin
            if (fifo_op[rd_ptr] == 3'b000) begin
              // NOP is answered locally; the ALU never sees it.
              rsp_valid  <= 1'b1;
              rsp_result <= '0;
              rsp_tag    <= fifo_tag[rd_ptr];
              rsp_err    <= 1'b0;
            end else begin
              alu_A     <= fifo_a[rd_ptr];
              alu_B     <= fifo_b[rd_ptr];
              alu_op    <= fifo_op[rd_ptr];
              cur_tag   <= fifo_tag[rd_ptr];
              alu_start <= 1'b1;
              timer     <= '0;
              state     <= S_ISSUE;
            end
          end
        end

        S_ISSUE: begin
          if (alu_done) begin
            rsp_valid  <= 1'b1;
            rsp_result <= alu_result;
            rsp_tag    <= cur_tag;
            rsp_err    <= 1'b0;
            alu_start  <= 1'b0;
            gap_cnt    <= '0;
            state      <= S_DRAIN;
          end else if (timer == TIMER_LAST) begin
            // Hung operation: abort and report it as an error response.
            rsp_valid  <= 1'b1;
            rsp_result <= '0;
            rsp_tag    <= cur_tag;
            rsp_err    <= 1'b1;
            alu_start  <= 1'b0;
            gap_cnt    <= '0;
            state      <= S_DRAIN;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        S_DRAIN: begin
          // Quiet period with alu_start low; stray done pulses are ignored.
          if (gap_cnt == GAP_LAST) state <= S_IDLE;
          else                     gap_cnt <= gap_cnt + 1'b1;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE) || !fifo_empty || rsp_valid;

endmodule

// File: tb/tb_tinyalu_cmd_sequencer.sv
module tb_tinyalu_cmd_sequencer;
  localparam int DEPTH   = 4;
  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 16;
  localparam int GAP     = 4;
  localparam int RW      = 16 + TAG_W + 1;

  // ---------------- clock / reset / DUT ----------------
  logic             clk;
  logic             reset_n;
  logic             cmd_valid, cmd_ready;
  logic [7:0]       cmd_a, cmd_b;
  logic [2:0]       cmd_op;
  logic [TAG_W-1:0] cmd_tag;
  logic [7:0]       alu_A, alu_B;
  logic [2:0]       alu_op;
  logic             alu_start, alu_done;
  logic [15:0]      alu_result;
  logic             rsp_valid, rsp_ready;
  logic [15:0]      rsp_result;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err, busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  tinyalu_cmd_sequencer #(
    .DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT), .GAP(GAP)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
    .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op),
    .alu_start(alu_start), .alu_done(alu_done), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
    .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_result(input logic [7:0] a, input logic [7:0] b,
                                             input logic [2:0] op);
    logic [15:0] r;
    r = 16'h0;
    if (op[2])           r = 16'(a) * 16'(b);
    else if (op == 3'd1) r = 16'(a) + 16'(b);
    else if (op == 3'd2) r = {8'h00, a & b};
    else if (op == 3'd3) r = {8'h00, a ^ b};
    return r;
  endfunction

  // ---------------- ALU responder ----------------
  // Single-cycle ops: done sampled 2 edges after the issue edge; mul: 5 edges.
  bit alu_hang = 0;
  bit spur_en  = 0;
  int rcnt;
  initial begin
    alu_done   = 1'b0;
    alu_result = 16'h0;
    rcnt       = 0;
    forever begin
      @(negedge clk);
      if (alu_start) begin
        rcnt++;
        if (!alu_hang && rcnt == (alu_op[2] ? 5 : 2)) begin
          alu_done   = 1'b1;
          alu_result = ref_result(alu_A, alu_B, alu_op);
        end else begin
          alu_done   = 1'b0;
          alu_result = 16'($urandom);
        end
      end else begin
        rcnt       = 0;
        alu_done   = spur_en && ($urandom_range(0, 5) == 0);
        alu_result = 16'($urandom);
      end
    end
  end

  // ---------------- behavioural model (transaction timeline) ----------------
  typedef struct {
    logic [7:0]       a;
    logic [7:0]       b;
    logic [2:0]       op;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  cmd_t             mq[$];
  cmd_t             m_cur, m_pop;
  int               n = 0;
  int               m_done_edge, m_drain_end = -1;
  bit               m_inflight = 0, m_cur_hang = 0, m_rv = 0;
  logic [15:0]      m_result = '0;
  logic [TAG_W-1:0] m_tag = '0;
  logic             m_err = 1'b0;
  int               pre_size;
  bit               pre_rv, pre_inf;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      m_inflight  = 0;
      m_rv        = 0;
      m_drain_end = -1;
      m_result    = '0;
      m_tag       = '0;
      m_err       = 1'b0;
    end else begin
      n++;
      pre_size = mq.size();
      pre_rv   = m_rv;
      pre_inf  = m_inflight;
      if (m_rv && rsp_ready) m_rv = 0;
      if (pre_inf && n == m_done_edge) begin
        m_result    = m_cur_hang ? 16'h0 : ref_result(m_cur.a, m_cur.b, m_cur.op);
        m_tag       = m_cur.tag;
        m_err       = m_cur_hang;
        m_rv        = 1;
        m_inflight  = 0;
        m_drain_end = n + GAP;
      end
      if (!pre_inf && !pre_rv && pre_size > 0 && n > m_drain_end) begin
        m_pop = mq.pop_front();
        if (m_pop.op == 3'd0) begin
          m_result = 16'h0;
          m_tag    = m_pop.tag;
          m_err    = 1'b0;
          m_rv     = 1;
        end else begin
          m_inflight  = 1;
          m_cur       = m_pop;
          m_cur_hang  = alu_hang;
          m_done_edge = n + (alu_hang ? TIMEOUT : (m_pop.op[2] ? 5 : 2));
        end
      end
      if (cmd_valid && pre_size < DEPTH)
        mq.push_back('{a: cmd_a, b: cmd_b, op: cmd_op, tag: cmd_tag});
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (reset_n) begin
      chk("cmd_ready", 32'(cmd_ready), 32'(mq.size() < DEPTH));
      chk("alu_start", 32'(alu_start), 32'(m_inflight));
      if (m_inflight) begin
        chk("alu_A",  32'(alu_A),  32'(m_cur.a));
        chk("alu_B",  32'(alu_B),  32'(m_cur.b));
        chk("alu_op", 32'(alu_op), 32'(m_cur.op));
      end
      chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
      if (m_rv) begin
        chk("rsp_result", 32'(rsp_result), 32'(m_result));
        chk("rsp_tag",    32'(rsp_tag),    32'(m_tag));
        chk("rsp_err",    32'(rsp_err),    32'(m_err));
      end
      chk("busy", 32'(busy),
          32'(m_inflight || (n < m_drain_end) || (mq.size() > 0) || m_rv));
    end
  end

  // ---------------- scoreboard for directed literals ----------------
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] rlog[$];
  int start_cycles = 0;
  int low_run = 0;
  int last_gap = 0;

  always @(posedge clk) begin
    if (reset_n && rsp_valid && rsp_ready) rlog.push_back({rsp_result, rsp_tag, rsp_err});
  end

  always @(negedge clk) begin
    if (alu_start) begin
      start_cycles++;
      if (low_run > 0) last_gap = low_run;
      low_run = 0;
    end else begin
      low_run++;
    end
  end

  task automatic expect_rsp(input logic [15:0] r, input logic [TAG_W-1:0] t, input logic e);
    exp_q.push_back({r, t, e});
  endtask

  task automatic check_log(input string name);
    logic [RW-1:0] e;
    chk({name, "_count"}, 32'(rlog.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && rlog.size() > 0) begin
      e = exp_q.pop_front();
      chk({name, "_rsp"}, 32'(rlog.pop_front()), 32'(e));
    end
    exp_q.delete();
    rlog.delete();
  endtask

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic send_cmd(input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] op, input logic [TAG_W-1:0] tag);
    int k;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag;
    cmd_valid = 1'b1;
    k = 0;
    while (!cmd_ready && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk("cmd_accept", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    repeat (2) @(negedge clk);
    k = 0;
    while (busy && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("wait_idle", 32'(busy), 32'd0);
  endtask

  bit rand_rr = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (rand_rr) rsp_ready = ($urandom_range(0, 9) < 6);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_tag = '0;
    repeat (3) @(negedge clk);
    chk("rst_alu_start", 32'(alu_start), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_result", 32'(rsp_result), 32'd0);
    chk("rst_rsp_tag", 32'(rsp_tag), 32'd0);
    chk("rst_alu_A", 32'(alu_A), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    reset_n = 1'b1;
    @(negedge clk);

    // single add
    rsp_ready = 1'b1; rlog.delete(); start_cycles = 0;
    send_cmd(8'd200, 8'd100, 3'b001, 4'd3);
    wait_idle();
    expect_rsp(16'd300, 4'd3, 1'b0);
    check_log("add");
    chk("add_start_cycles", 32'(start_cycles), 32'd2);

    // mul followed back-to-back by an add: gap check
    last_gap = 0;
    send_cmd(8'hFF, 8'hFF, 3'b100, 4'd7);
    send_cmd(8'h01, 8'hFF, 3'b001, 4'd8);
    wait_idle();
    expect_rsp(16'hFE01, 4'd7, 1'b0);
    expect_rsp(16'h0100, 4'd8, 1'b0);
    check_log("mul");
    chk("mul_gap", 32'(last_gap), 32'(GAP + 1));

    // fill the FIFO with responses blocked
    rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: begin cmd_a = 8'd1;  cmd_b = 8'd2;  cmd_op = 3'b001; end
        1: begin cmd_a = 8'hF0; cmd_b = 8'h3C; cmd_op = 3'b010; end
        2: begin cmd_a = 8'hF0; cmd_b = 8'h3C; cmd_op = 3'b011; end
        3: begin cmd_a = 8'h00; cmd_b = 8'h00; cmd_op = 3'b001; end
        4: begin cmd_a = 8'hAB; cmd_b = 8'hCD; cmd_op = 3'b000; end
        default: begin cmd_a = 8'h55; cmd_b = 8'hAA; cmd_op = 3'b011; end
      endcase
      cmd_tag = TAG_W'(i + 1);
      cmd_valid = 1'b1;
      chk($sformatf("fill_ready_%0d", i), 32'(cmd_ready), 32'(i < 5));
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("hold_valid", 32'(rsp_valid), 32'd1);
    chk("hold_result", 32'(rsp_result), 32'd3);
    chk("hold_tag", 32'(rsp_tag), 32'd1);
    chk("hold_full", 32'(cmd_ready), 32'd0);
    repeat (5) @(negedge clk);
    chk("hold_result2", 32'(rsp_result), 32'd3);
    chk("hold_tag2", 32'(rsp_tag), 32'd1);
    rsp_ready = 1'b1;
    wait_idle();
    expect_rsp(16'd3,    4'd1, 1'b0);
    expect_rsp(16'h0030, 4'd2, 1'b0);
    expect_rsp(16'h00CC, 4'd3, 1'b0);
    expect_rsp(16'h0000, 4'd4, 1'b0);
    expect_rsp(16'h0000, 4'd5, 1'b0);
    check_log("fill");

    // nop
    start_cycles = 0;
    send_cmd(8'h12, 8'h34, 3'b000, 4'd9);
    wait_idle();
    expect_rsp(16'h0, 4'd9, 1'b0);
    check_log("nop");
    chk("nop_start_cycles", 32'(start_cycles), 32'd0);

    // timeout, then normal recovery
    alu_hang = 1; start_cycles = 0;
    send_cmd(8'd5, 8'd6, 3'b001, 4'd2);
    wait_idle();
    chk("to_start_cycles", 32'(start_cycles), 32'(TIMEOUT));
    alu_hang = 0;
    send_cmd(8'h0F, 8'hFF, 3'b010, 4'd4);
    wait_idle();
    expect_rsp(16'h0, 4'd2, 1'b1);
    expect_rsp(16'h000F, 4'd4, 1'b0);
    check_log("timeout");

    // reset mid-operation with commands queued
    rsp_ready = 1'b0;
    send_cmd(8'd3, 8'd4, 3'b100, 4'd1);
    send_cmd(8'd5, 8'd6, 3'b001, 4'd2);
    send_cmd(8'd7, 8'd8, 3'b011, 4'd3);
    chk("pre_rst_start", 32'(alu_start), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_start", 32'(alu_start), 32'd0);
    chk("async_rst_valid", 32'(rsp_valid), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    rlog.delete();
    rsp_ready = 1'b1;
    repeat (20) @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_rsps", 32'(rlog.size()), 32'd0);

    // randomized traffic
    spur_en = 1; rand_rr = 1;
    for (int i = 0; i < 120; i++) begin
      send_cmd(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), TAG_W'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    rand_rr = 0; rsp_ready = 1'b1;
    wait_idle();
    spur_en = 0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
